// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue: fetch-PC owner plus DEPTH-entry prefetch FIFO feeding decode.  |
// | Optional FETCH_PERF_EN builds redirect/stall/empty perf counters.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INS_W-1:0]             imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INS_W-1:0]             out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  perf_redirects,
  output logic [31:0]                  perf_stalls,
  output logic [31:0]                  perf_empty
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(DEPTH);

  logic [PC_W-1:0]  r_fpc;
  logic             r_ifv;
  logic [PC_W-1:0]  r_ifpc;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_pc_mem  [DEPTH];
  logic [INS_W-1:0] r_ins_mem [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic             w_req;
  logic [CNT_W:0]   w_credit;
  logic             w_unused;

  assign w_unused = &{1'b0, redirect_pc[1:0]};

  // Credit counts the in-flight word, so a request is only made when its
  // data is guaranteed a free slot on arrival.
  always_comb begin
    w_pop    = out_valid & out_ready;
    w_push   = r_ifv & ~redirect_valid;
    w_credit = {1'b0, r_count} + {{CNT_W{1'b0}}, r_ifv} - {{CNT_W{1'b0}}, w_pop};
    w_req    = ~redirect_valid & (w_credit < C_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc   <= RESET_PC;
      r_ifv   <= 1'b0;
      r_ifpc  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_fpc   <= {redirect_pc[PC_W-1:2], 2'b00};
      r_ifv   <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_req) begin
        r_fpc  <= r_fpc + PC_W'(4);
        r_ifpc <= r_fpc;
      end
      r_ifv <= w_req;
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_pc_mem[r_wr]  <= r_ifpc;
      r_ins_mem[r_wr] <= imem_rdata;
    end
  end

  assign imem_addr = r_fpc;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd]  : '0;
  assign out_instr = out_valid ? r_ins_mem[r_rd] : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_redirects <= '0;
      r_perf_stalls    <= '0;
      r_perf_empty     <= '0;
    end else begin
      if (redirect_valid)          r_perf_redirects <= r_perf_redirects + 32'd1;
      if (out_valid && !out_ready) r_perf_stalls    <= r_perf_stalls + 32'd1;
      if (!out_valid)              r_perf_empty     <= r_perf_empty + 32'd1;
    end
  end

  assign perf_redirects = r_perf_redirects;
  assign perf_stalls    = r_perf_stalls;
  assign perf_empty     = r_perf_empty;
`else
  assign perf_redirects = '0;
  assign perf_stalls    = '0;
  assign perf_empty     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// Bench for fetch_queue: directed timing scenarios plus a randomized run
// checked against an expected-PC-stream model.
module tb_fetch_queue;
  localparam int              PC_W     = 9;
  localparam int              INS_W    = 32;
  localparam int              DEPTH    = 4;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam logic [INS_W-1:0] TAG     = 32'h1000_0000;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [PC_W-1:0]            imem_addr;
  logic [INS_W-1:0]           imem_rdata;
  logic                       redirect_valid;
  logic [PC_W-1:0]            redirect_pc;
  logic                       out_valid;
  logic [PC_W-1:0]            out_pc;
  logic [INS_W-1:0]           out_instr;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [31:0]                perf_redirects, perf_stalls, perf_empty;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count),
    .perf_redirects(perf_redirects), .perf_stalls(perf_stalls), .perf_empty(perf_empty)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word depends on the address presented.
  always @(posedge clk) imem_rdata <= TAG | INS_W'(imem_addr);

  task automatic do_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 9'h100;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_pc !== '0) begin n_errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_checks++; if (out_instr !== '0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    n_checks++; if ({perf_redirects, perf_stalls, perf_empty} !== '0) begin n_errors++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_redirects, perf_stalls, perf_empty); end
    redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    reset = 1'b0; out_ready = 1'b1;
    n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("FAIL stream_addr0: got %h want %h", imem_addr, RESET_PC); end
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_c1_valid: got %0b want 0", out_valid); end
      end else begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== PC_W'((k-2)*4) || out_instr !== (TAG | INS_W'((k-2)*4))) begin
          n_errors++; $display("FAIL stream_c%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h", k, out_valid, out_pc, out_instr, PC_W'((k-2)*4));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        n_checks++; if (out_valid !== 1'b1 || out_pc !== '0 || out_instr !== TAG) begin
          n_errors++; $display("FAIL stall_head_c%0d: got v=%0b pc=%h ins=%h want pc=0", k, out_valid, out_pc, out_instr); end
      end
      @(negedge clk);
    end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL stall_count: got %0d want 4", count); end
    n_checks++; if (imem_addr !== 9'h010) begin n_errors++; $display("FAIL stall_addr: got %h want 010", imem_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_pc !== PC_W'(i*4)) begin
        n_errors++; $display("FAIL drain_%0d: got v=%0b pc=%h want pc=%h", i, out_valid, out_pc, PC_W'(i*4)); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (count !== 3'd3 || imem_addr !== 9'h010) begin
      n_errors++; $display("FAIL redir_setup: got count=%0d addr=%h want 3/010", count, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 9'h040;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 9'h040 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL redir_t1: got addr=%h v=%0b want 040/0", imem_addr, out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL redir_t2: got v=%0b want 0", out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_pc !== PC_W'(9'h040 + i*4)) begin
        n_errors++; $display("FAIL redir_head_%0d: got v=%0b pc=%h want %h", i, out_valid, out_pc, PC_W'(9'h040 + i*4)); end
    end
  endtask

  task automatic test_redirect_pop();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rpop_setup: got v=%0b want 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = 9'h043;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (count !== '0 || imem_addr !== 9'h040) begin
      n_errors++; $display("FAIL rpop_t1: got count=%0d addr=%h want 0/040", count, imem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h040) begin
      n_errors++; $display("FAIL rpop_head: got v=%0b pc=%h want 040", out_valid, out_pc); end
    @(negedge clk);
    n_checks++; if (out_pc !== 9'h044) begin n_errors++; $display("FAIL rpop_next: got pc=%h want 044", out_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 9'h1FC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 9'h1FC) begin n_errors++; $display("FAIL wrap_addr: got %h want 1fc", imem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h1FC || out_instr !== (TAG | 32'h1FC)) begin
      n_errors++; $display("FAIL wrap_head: got pc=%h ins=%h want 1fc", out_pc, out_instr); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 9'h000 || out_instr !== TAG) begin
      n_errors++; $display("FAIL wrap_zero: got pc=%h ins=%h want 000", out_pc, out_instr); end
  endtask

  // Model: the head is always the next PC of the expected in-order stream;
  // a flush restarts the stream at the aligned target after a two-cycle bubble.
  task automatic test_random();
    logic [PC_W-1:0]  exp_next, last_tgt, tgt, prev_pc;
    logic [INS_W-1:0] prev_ins;
    logic             prev_stall;
    int               since;
    do_reset();
    exp_next = RESET_PC; last_tgt = RESET_PC; since = 1; prev_stall = 1'b0;
    prev_pc = '0; prev_ins = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++; if (out_valid !== (count != 0) || count > DEPTH) begin
        n_errors++; $display("FAIL rnd_count_%0d: got v=%0b count=%0d want v=(count!=0), count<=%0d", cyc, out_valid, count, DEPTH); end
      if (since == 1) begin
        n_checks++; if (imem_addr !== last_tgt) begin
          n_errors++; $display("FAIL rnd_addr_%0d: got %h want %h", cyc, imem_addr, last_tgt); end
      end
      n_checks++; if (out_valid !== (since >= 3)) begin
        n_errors++; $display("FAIL rnd_valid_%0d: got %0b want %0b", cyc, out_valid, since >= 3); end
      if (prev_stall) begin
        n_checks++; if (out_pc !== prev_pc || out_instr !== prev_ins) begin
          n_errors++; $display("FAIL rnd_hold_%0d: got pc=%h ins=%h want pc=%h ins=%h", cyc, out_pc, out_instr, prev_pc, prev_ins); end
      end
      if (out_valid) begin
        n_checks++; if (out_pc !== exp_next || out_instr !== (TAG | INS_W'(exp_next))) begin
          n_errors++; $display("FAIL rnd_head_%0d: got pc=%h ins=%h want pc=%h", cyc, out_pc, out_instr, exp_next); end
      end
      out_ready      = ((cyc / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      tgt            = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      redirect_pc    = tgt;
      if (redirect_valid) begin
        exp_next = {tgt[PC_W-1:2], 2'b00}; last_tgt = exp_next; since = 1; prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) exp_next = exp_next + PC_W'(4);
        prev_stall = out_valid && !out_ready;
        since++;
      end
      prev_pc = out_pc; prev_ins = out_instr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_perf();
    int e_red, e_stall, e_empty;
`ifdef FETCH_PERF_EN
    e_red = 3; e_stall = 5; e_empty = 8;
`else
    e_red = 0; e_stall = 0; e_empty = 0;
`endif
    do_reset();
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      redirect_valid = 1'b1; redirect_pc = 9'h080;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    n_checks++; if (perf_redirects !== 32'(e_red)) begin n_errors++; $display("FAIL perf_redirects: got %0d want %0d", perf_redirects, e_red); end
    n_checks++; if (perf_stalls !== 32'(e_stall)) begin n_errors++; $display("FAIL perf_stalls: got %0d want %0d", perf_stalls, e_stall); end
    n_checks++; if (perf_empty !== 32'(e_empty)) begin n_errors++; $display("FAIL perf_empty: got %0d want %0d", perf_empty, e_empty); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== '0 || out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      n_errors++; $display("FAIL midreset_state: got count=%0d v=%0b addr=%h want 0/0/%h", count, out_valid, imem_addr, RESET_PC); end
    n_checks++; if ({perf_redirects, perf_stalls, perf_empty} !== '0) begin n_errors++;
      $display("FAIL midreset_perf: got %0d/%0d/%0d want 0/0/0", perf_redirects, perf_stalls, perf_empty); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
      n_errors++; $display("FAIL midreset_restart: got v=%0b pc=%h want 1/%h", out_valid, out_pc, RESET_PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_random();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
